// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronized input, mid-bit sampling from a single bit-timing
// counter, registered byte output with one-cycle valid / frame-error strobes.
module uart_rx #(
    parameter int CLKS_PER_BIT = 2500,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t                 r_state, w_state_next;
    logic [CW-1:0]          r_cnt, w_cnt_next;
    logic [2:0]             r_idx, w_idx_next;
    logic [7:0]             r_shift, w_shift_next;
    logic [7:0]             r_data, w_data_next;
    logic                   r_valid, w_valid_next;
    logic                   r_ferr, w_ferr_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx_s;

    // Synchronizer resets to the idle (high) line level so reset never looks like a start edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '1;
        end else begin
            r_sync[0] <= i_rx;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_rx_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
            r_data  <= w_data_next;
            r_valid <= w_valid_next;
            r_ferr  <= w_ferr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_data_next  = r_data;
        w_valid_next = 1'b0;
        w_ferr_next  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (!w_rx_s) begin
                    w_state_next = START;
                end
            end
            START: begin
                if (r_cnt == HALF_M1) begin
                    w_cnt_next = '0;
                    w_idx_next = '0;
                    // A line back high at mid start bit was a glitch, not a frame.
                    w_state_next = w_rx_s ? IDLE : DATA;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            DATA: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_next            = '0;
                    w_shift_next[r_idx]   = w_rx_s;
                    if (r_idx == 3'd7) begin
                        w_state_next = STOP;
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            STOP: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_next = '0;
                    if (w_rx_s) begin
                        w_data_next  = r_shift;
                        w_valid_next = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_ferr_next  = 1'b1;
                        w_state_next = WAIT_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            WAIT_IDLE: begin
                w_cnt_next = '0;
                if (w_rx_s) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_ferr;
    assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: table of frames plus hand-written
// sequences for glitch rejection, back-to-back frames and reset mid-frame.
module tb_uart_rx;

    logic       clk;
    logic       i_rst;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_busy;

    uart_rx #(
        .CLKS_PER_BIT(16),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_rx       (i_rx),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_frame_err(o_frame_err),
        .o_busy     (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge.
    int         nvalid = 0, nfe = 0, nbusy = 0, viol = 0;
    int         valid_cyc = 0, valid_cyc_prev = 0;
    logic [7:0] valid_data = '0, valid_data_prev = '0;
    logic       prev_v = 1'b0, prev_f = 1'b0;
    always @(negedge clk) begin
        if (o_valid) begin
            nvalid++;
            valid_cyc_prev  = valid_cyc;
            valid_cyc       = cyc;
            valid_data_prev = valid_data;
            valid_data      = o_data;
        end
        if (o_frame_err) nfe++;
        if (o_busy) nbusy++;
        if (o_valid && o_frame_err) viol++;
        if (o_valid && prev_v) viol++;
        if (o_frame_err && prev_f) viol++;
        prev_v = o_valid;
        prev_f = o_frame_err;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int last_start = 0;

    // p100: transmitter bit period in hundredths of a clock.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int p100);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        last_start = cyc;
        for (int i = 0; i < 10; i++) begin
            i_rx = bits[i];
            tick(((i + 1) * p100) / 100 - (i * p100) / 100);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         p100;
        int         hold;
        int         exp_v;
        int         exp_fe;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int v0, f0, b0;
        logic [7:0] b5a;

        vecs[0] = '{8'hA5, 1'b1, 1600, 0,  1, 0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 1600, 48, 0, 1, 8'hA5};
        vecs[2] = '{8'h55, 1'b1, 1648, 0,  1, 0, 8'h55};
        vecs[3] = '{8'hAA, 1'b1, 1648, 0,  1, 0, 8'hAA};
        vecs[4] = '{8'h55, 1'b1, 1552, 0,  1, 0, 8'h55};
        vecs[5] = '{8'hAA, 1'b1, 1552, 0,  1, 0, 8'hAA};
        vecs[6] = '{8'h00, 1'b1, 1600, 0,  1, 0, 8'h00};
        vecs[7] = '{8'hFF, 1'b1, 1600, 0,  1, 0, 8'hFF};

        i_rst = 1'b1;
        i_rx  = 1'b1;
        tick(3);
        chk("rst_data",  int'(o_data), 0);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_ferr",  int'(o_frame_err), 0);
        chk("rst_busy",  int'(o_busy), 0);
        i_rst = 1'b0;
        tick(5);

        for (int k = 0; k < 8; k++) begin
            v0 = nvalid;
            f0 = nfe;
            send_frame(vecs[k].data, vecs[k].stop, vecs[k].p100);
            if (vecs[k].hold > 0) begin
                i_rx = 1'b0;
                tick(vecs[k].hold);
                chk($sformatf("v%0d_busy_low", k), int'(o_busy), 1);
                i_rx = 1'b1;
            end
            tick(40);
            chk($sformatf("v%0d_valid", k), nvalid - v0, vecs[k].exp_v);
            chk($sformatf("v%0d_ferr", k), nfe - f0, vecs[k].exp_fe);
            chk($sformatf("v%0d_data", k), int'(o_data), int'(vecs[k].exp_data));
            chk($sformatf("v%0d_idle", k), int'(o_busy), 0);
            if (k == 0) chk("latency", valid_cyc - last_start, 155);
        end

        // Back-to-back frames with no idle gap.
        v0 = nvalid;
        f0 = nfe;
        send_frame(8'h00, 1'b1, 1600);
        send_frame(8'hFF, 1'b1, 1600);
        tick(40);
        chk("b2b_count", nvalid - v0, 2);
        chk("b2b_spacing", valid_cyc - valid_cyc_prev, 160);
        chk("b2b_first", int'(valid_data_prev), 8'h00);
        chk("b2b_second", int'(valid_data), 8'hFF);
        chk("b2b_ferr", nfe - f0, 0);

        // Four-cycle low glitch on an idle line.
        v0 = nvalid;
        f0 = nfe;
        b0 = nbusy;
        i_rx = 1'b0;
        tick(4);
        i_rx = 1'b1;
        tick(30);
        chk("glitch_busy_cycles", nbusy - b0, 8);
        chk("glitch_strobes", (nvalid - v0) + (nfe - f0), 0);
        chk("glitch_data", int'(o_data), 8'hFF);

        // Reset during data bit 4 of 0x5A, then receive 0xC3.
        v0 = nvalid;
        f0 = nfe;
        b5a = 8'h5A;
        i_rx = 1'b0;
        tick(16);
        for (int i = 0; i < 4; i++) begin
            i_rx = b5a[i];
            tick(16);
        end
        i_rx = b5a[4];
        tick(8);
        chk("mid_busy", int'(o_busy), 1);
        #2 i_rst = 1'b1;
        #1;
        chk("async_rst_busy", int'(o_busy), 0);
        chk("async_rst_data", int'(o_data), 0);
        i_rx = 1'b1;
        tick(3);
        i_rst = 1'b0;
        tick(30);
        chk("abandon_strobes", (nvalid - v0) + (nfe - f0), 0);
        chk("abandon_data", int'(o_data), 0);
        v0 = nvalid;
        send_frame(8'hC3, 1'b1, 1600);
        tick(40);
        chk("after_rst_valid", nvalid - v0, 1);
        chk("after_rst_data", int'(o_data), 8'hC3);
        chk("after_rst_ferr", nfe - f0, 0);

        chk("strobe_rules", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
